// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
// Owns the single SDRAM controller port. While a game is loading, loader bytes
// are queued in a small FIFO and each one is issued as a write that spans one
// full NES memory slot (slot edge to slot edge). Once loading is done and the
// FIFO has drained, the port is handed to the NES core and the NES is released
// from reset. Dropping load_done while running goes back to loading.
module sdram_port_arbiter #(
    parameter logic [1:0] SLOT_PHASE = 2'd3,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  nes_ce,
    input  logic        load_done,
    input  logic        loader_write,
    input  logic [21:0] loader_addr,
    input  logic [7:0]  loader_data,
    input  logic [21:0] nes_addr,
    input  logic        nes_read_cpu,
    input  logic        nes_read_ppu,
    input  logic        nes_write,
    input  logic [7:0]  nes_dout,
    output logic [24:0] sd_addr,
    output logic        sd_we,
    output logic [7:0]  sd_din,
    output logic        sd_oe_a,
    output logic        sd_oe_b,
    output logic        sd_drive,
    output logic        nes_reset,
    output logic        fifo_full,
    output logic        overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    // Port ownership states
    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;

    // Loader FIFO: entries are {addr, data}
    logic [29:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [29:0]      head;

    // Write currently presented to the SDRAM while loading
    logic [21:0]      wr_addr;
    logic [7:0]       wr_data;
    logic             wr_active;

    logic             slot_edge;
    logic             loading;
    logic             fifo_empty;
    logic             full;
    logic             push_req;
    logic             do_pop;
    logic             do_push;
    logic             drop;

    assign slot_edge  = (nes_ce == SLOT_PHASE);
    assign loading    = (state != ST_RUN);
    assign fifo_empty = (count == '0);
    assign full       = (count == DEPTH_C);
    assign head       = fifo_mem[rd_ptr];

    // Loader strobes are ignored entirely while the NES owns the port.
    assign push_req = loader_write && loading;
    assign do_pop   = slot_edge && loading && !fifo_empty;
    // A pop in the same cycle frees the slot being written, so a full FIFO
    // can still accept the byte.
    assign do_push  = push_req && (!full || do_pop);
    assign drop     = push_req && full && !do_pop;

    assign fifo_full = full;
    assign nes_reset = (state != ST_RUN);

    // Next-state decode for port ownership
    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD: begin
                if (load_done)
                    state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Only hand over on a slot edge with nothing left to write,
                // so the last loader write ends on the same edge.
                if (slot_edge && fifo_empty)
                    state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!load_done)
                    state_nxt = ST_LOAD;
            end
            default: state_nxt = ST_LOAD;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset)
            state <= ST_LOAD;
        else
            state <= state_nxt;
    end

    // FIFO storage; contents need no reset since the pointers define validity
    always_ff @(posedge clock) begin
        if (do_push)
            fifo_mem[wr_ptr] <= {loader_addr, loader_data};
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky drop flag, cleared only by reset
    always_ff @(posedge clock) begin
        if (reset)
            overflow <= 1'b0;
        else if (drop)
            overflow <= 1'b1;
    end

    // Issue one write per slot; each is held from slot edge to slot edge
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_addr   <= '0;
            wr_data   <= '0;
            wr_active <= 1'b0;
        end else if (!loading) begin
            wr_active <= 1'b0;
        end else if (slot_edge) begin
            if (do_pop) begin
                wr_addr   <= head[29:8];
                wr_data   <= head[7:0];
                wr_active <= 1'b1;
            end else begin
                wr_active <= 1'b0;
            end
        end
    end

    // SDRAM port mux: loader writes while loading, NES pass-through in RUN
    always_comb begin
        sd_addr  = {3'b000, wr_addr};
        sd_din   = wr_data;
        sd_we    = wr_active;
        sd_drive = wr_active;
        sd_oe_a  = 1'b0;
        sd_oe_b  = 1'b0;
        if (state == ST_RUN) begin
            sd_addr  = {3'b000, nes_addr};
            sd_din   = nes_dout;
            sd_we    = nes_write;
            sd_drive = nes_write;
            sd_oe_a  = nes_read_cpu;
            sd_oe_b  = nes_read_ppu;
        end
    end

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Owns the single SDRAM controller port and sequences it between the flash game loader and the running NES core. It buffers loader bytes in a small FIFO and issues each one as a write during one full NES memory slot. It holds the NES in reset until the last loaded byte has been committed, then hands the port to the NES CPU/PPU. It sits between `game_loader`, `NES` and `sdram`, and replaces the ad-hoc loader-write capture logic and the tristate-direction mux in the top level.

## Interface
- `SLOT_PHASE`, 2'd3: `nes_ce` value on whose edge loader writes are issued; matches `run_nes`.
- `FIFO_DEPTH`, 4: loader FIFO entries; power of two, 2..16.
- `clock`  in  1  system clock (21 MHz domain); all logic on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `nes_ce`  in  2  free-running NES phase counter.
- `load_done`  in  1  from `game_loader`.
- `loader_write`  in  1  one-cycle strobe: `loader_addr`/`loader_data` valid.
- `loader_addr`  in  22  loader byte address.
- `loader_data`  in  8  loader byte.
- `nes_addr`  in  22  NES memory address.
- `nes_read_cpu`, `nes_read_ppu`, `nes_write`  in  1 each  NES memory strobes.
- `nes_dout`  in  8  NES write data.
- `sd_addr`  out  25  to `sdram.addr`.
- `sd_we`  out  1  to `sdram.we`.
- `sd_din`  out  8  to `sdram.din`.
- `sd_oe_a`, `sd_oe_b`  out  1 each  to `sdram.oeA` and `sdram.oeB`.
- `sd_drive`  out  1  1 = FPGA drives the SDRAM data bus (top level inverts it for `T`).
- `nes_reset`  out  1  NES core reset.
- `fifo_full`  out  1  FIFO at `FIFO_DEPTH` entries.
- `overflow`  out  1  sticky: a loader byte was dropped.

## Operation
- The FIFO holds {addr, data}, 30 bits wide, with wrapping pointers and a count of width clog2(`FIFO_DEPTH`)+1.
- States are LOAD, DRAIN and RUN.
- LOAD:
  - Push on `loader_write`.
  - Goes to DRAIN when `load_done`=1.
- DRAIN:
  - Pushes still accepted.
  - On a slot edge (`nes_ce`==`SLOT_PHASE`) with FIFO empty, goes to RUN.
- RUN:
  - `loader_write` is ignored. It is neither pushed nor counted as an overflow.
  - Goes to LOAD in any cycle where `load_done`=0. This is the reload path; the FIFO is not cleared.
- Write issue, on a slot edge in LOAD or DRAIN:
  - FIFO non-empty: pop the head into `wr_addr`/`wr_data` and set `wr_active`=1.
  - FIFO empty: clear `wr_active`.
  - In RUN, `wr_active` is held at 0.
- Push/pop rules:
  - Push and pop in the same cycle: count unchanged, legal even when the FIFO is full.
  - Push while full with no pop: byte dropped, `overflow` set, count unchanged.
- Outputs in LOAD/DRAIN:
  - `sd_addr`={3'b000,`wr_addr`}, `sd_din`=`wr_data`.
  - `sd_we`=`sd_drive`=`wr_active`.
  - `sd_oe_a`=`sd_oe_b`=0.
- Outputs in RUN (combinational pass-through):
  - `sd_addr`={3'b000,`nes_addr`}, `sd_din`=`nes_dout`.
  - `sd_we`=`sd_drive`=`nes_write`.
  - `sd_oe_a`=`nes_read_cpu`, `sd_oe_b`=`nes_read_ppu`.
- `nes_reset` = (state != RUN), decoded from the state register.
- `fifo_full` = (count == `FIFO_DEPTH`).
- `overflow` is cleared only by `reset`.

## Timing
- Reset values:
  - state LOAD, FIFO empty, `wr_active`=0, `overflow`=0.
  - `nes_reset`=1, `sd_we`=0, `sd_drive`=0, `sd_oe_a`=`sd_oe_b`=0, `fifo_full`=0, `sd_addr`=0, `sd_din`=0.
- `reset` asserted mid-write ends `sd_we` on the next edge; the FIFO contents are discarded.
- Push latency: a byte strobed in cycle t is poppable from edge t+1. If t's edge is itself a slot edge, it waits for the next slot edge.
- Each issued write holds `sd_we`=1 with stable address and data for exactly 4 clocks, slot edge to slot edge. Back-to-back entries give continuous `sd_we` with the address changing every 4 clocks.
- Sustained throughput: 1 byte per 4 clocks. A loader faster than that must respect `fifo_full`.
- RUN is entered only on a slot edge. `wr_active` falls on that same edge, so there is no cycle where loader and NES both drive.
- `nes_reset` falls on the same edge as RUN entry. It rises the cycle after `load_done` falls while in RUN.
- Worst-case DRAIN time is (`FIFO_DEPTH`+1)×4 clocks.

## Test plan
- **Reset:**
  - Stimulus: reset for 3 clocks, all inputs 0.
  - Required: all outputs equal their reset values; `nes_reset`=1.
- **Single load byte:**
  - Stimulus: `loader_write` with addr 0x000010, data 0xA5, two cycles before a slot edge.
  - Required: from that slot edge, `sd_we`=`sd_drive`=1, `sd_addr`=0x0000010, `sd_din`=0xA5 for exactly 4 clocks; FIFO empty afterwards.
- **Burst and overflow (`FIFO_DEPTH`=4):**
  - Stimulus: 6 consecutive `loader_write` strobes, data 0x01–0x06, starting right after a slot edge.
  - Required: 0x01–0x05 are written in order, one per slot; 0x06 is dropped; `fifo_full` and `overflow`=1.
- **Drain to run:**
  - Stimulus: assert `load_done` with 2 entries queued.
  - Required: both writes complete; RUN is entered on the following empty slot edge; `nes_reset` falls on that same edge; `sd_we` never overlaps a NES strobe.
- **Run pass-through:**
  - Stimulus: `nes_read_ppu`=1 with `nes_addr`=0x200123; then `nes_write` with 0x3C; concurrent `loader_write` strobes.
  - Required: `sd_oe_b`=1 and `sd_addr`=0x0200123; then `sd_we`=`sd_drive`=1 and `sd_din`=0x3C; loader strobes are ignored and `overflow` is unchanged.
- **Reload:**
  - Stimulus: drop `load_done` while in RUN.
  - Required: `nes_reset`=1 the next cycle, state LOAD, the NES strobes no longer reach the SDRAM outputs, and new loader bytes are written again.
